imm_gen_pipe: RTL and testbench

//  Registered, handshaked immediate generator for the decode stage. Accepts instr[31:7] plus a

---
 rtl/imm_gen_pkg.sv | 20 ++
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_core.sv | 53 +++++
 rtl/imm_gen_pipe.sv | 90 +++++++++
 tb/tb_imm_gen_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator: format-select encoding and width helper.
package imm_gen_pkg;

   typedef logic [2:0] imm_src_t;

   localparam imm_src_t IMM_I     = 3'b000;
   localparam imm_src_t IMM_S     = 3'b001;
   localparam imm_src_t IMM_B     = 3'b010;
   localparam imm_src_t IMM_J     = 3'b011;
   localparam imm_src_t IMM_U     = 3'b100;
   localparam imm_src_t IMM_SHAMT = 3'b101;
   localparam imm_src_t IMM_ZIMM  = 3'b110;
   localparam imm_src_t IMM_ILL   = 3'b111;

   // Width of the shift-amount immediate for a given register width.
   function automatic int shamt_width(input int xlen);
      return (xlen == 64) ? 6 : 5;
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle for the immediate generator: instruction beat in, extended immediate out.
interface imm_gen_pipe_if
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [24:0]      in_instr;
   imm_src_t         in_imm_src;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_imm_src, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_gen_core.sv
// Combinational immediate extender. Defining IMM_GEN_ZICSR_EN enables the ZIMM format (110);
// otherwise 110 is reported as illegal. instr_i[0] corresponds to instruction bit 7.
module imm_gen_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [24:0]             instr_i,
   input  imm_src_t                imm_src_i,
   output logic signed [XLEN-1:0]  imm_o,
   output logic                    illegal_o
);
   localparam int SHW = shamt_width(XLEN);

   logic               sgn;
   logic signed [31:0] imm32;

   assign sgn = instr_i[24];

   // 32-bit formats are built first, then sign-extended to XLEN by the signed size cast.
   always_comb begin
      imm32     = '0;
      imm_o     = '0;
      illegal_o = 1'b0;
      case (imm_src_i)
         IMM_I: begin
            imm32 = {{20{sgn}}, instr_i[24:13]};
            imm_o = XLEN'(imm32);
         end
         IMM_S: begin
            imm32 = {{20{sgn}}, instr_i[24:18], instr_i[4:0]};
            imm_o = XLEN'(imm32);
         end
         IMM_B: begin
            imm32 = {{19{sgn}}, sgn, instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
            imm_o = XLEN'(imm32);
         end
         IMM_J: begin
            imm32 = {{11{sgn}}, sgn, instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
            imm_o = XLEN'(imm32);
         end
         IMM_U: begin
            imm32 = {instr_i[24:5], 12'b0};
            imm_o = XLEN'(imm32);
         end
         IMM_SHAMT: imm_o = XLEN'(instr_i[13 +: SHW]);
`ifdef IMM_GEN_ZICSR_EN
         IMM_ZIMM:  imm_o = XLEN'(instr_i[12:8]);
`endif
         default:   illegal_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer so in_ready is a flop output.
// Optional ZIMM format is controlled by IMM_GEN_ZICSR_EN (see imm_gen_core).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);
   typedef struct packed {
      logic signed [XLEN-1:0] imm;
      logic [TAG_W-1:0]       tag;
      logic                   ill;
   } beat_t;

   logic signed [XLEN-1:0] ext_imm;
   logic                   ext_ill;
   beat_t                  in_beat;

   beat_t out_q, out_d;
   beat_t skid_q, skid_d;
   logic  out_vld_q, out_vld_d;
   logic  skid_vld_q, skid_vld_d;
   logic  accept, consume;

   imm_gen_core #(.XLEN(XLEN)) u_core (
      .instr_i   (bus.in_instr),
      .imm_src_i (bus.in_imm_src),
      .imm_o     (ext_imm),
      .illegal_o (ext_ill)
   );

   assign in_beat = '{imm: ext_imm, tag: bus.in_tag, ill: ext_ill};
   assign accept  = bus.in_valid && !skid_vld_q;
   assign consume = out_vld_q && bus.out_ready;

   // The skid is only ever occupied while the output register is, so an empty output
   // implies an empty skid and the new beat goes straight to the output.
   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q) begin
         if (accept) begin
            out_d     = in_beat;
            out_vld_d = 1'b1;
         end
      end else if (consume) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            out_d = in_beat;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_beat;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign bus.in_ready    = !skid_vld_q;
   assign bus.out_valid   = out_vld_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_tag     = out_q.tag;
   assign bus.out_illegal = out_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: format tables at XLEN=32 and 64, plus handshake corner cases.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));
   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));

   typedef struct {
      logic [31:0] instr;
      imm_src_t    src;
      logic [63:0] exp;
      logic        ill;
   } vec_t;

   vec_t v32[14];
   vec_t v64[6];

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive32(input logic v, input logic [31:0] instr, input imm_src_t src,
                          input logic [4:0] tag);
      b32.in_valid   = v;
      b32.in_instr   = instr[31:7];
      b32.in_imm_src = src;
      b32.in_tag     = tag;
   endtask

   logic [63:0] zexp;
   logic        zill;

   initial begin
`ifdef IMM_GEN_ZICSR_EN
      zexp = 64'h1F; zill = 1'b0;
`else
      zexp = 64'h0;  zill = 1'b1;
`endif
      v32[0]  = '{32'hFFF00093, IMM_I,     64'hFFFF_FFFF, 1'b0};
      v32[1]  = '{32'h7FF00013, IMM_I,     64'h0000_07FF, 1'b0};
      v32[2]  = '{32'h00A12423, IMM_S,     64'h0000_0008, 1'b0};
      v32[3]  = '{32'hFE112E23, IMM_S,     64'hFFFF_FFFC, 1'b0};
      v32[4]  = '{32'hFE000EE3, IMM_B,     64'hFFFF_FFFC, 1'b0};
      v32[5]  = '{32'h0080006F, IMM_J,     64'h0000_0008, 1'b0};
      v32[6]  = '{32'hFFDFF06F, IMM_J,     64'hFFFF_FFFC, 1'b0};
      v32[7]  = '{32'h12345037, IMM_U,     64'h1234_5000, 1'b0};
      v32[8]  = '{32'h80000037, IMM_U,     64'h8000_0000, 1'b0};
      v32[9]  = '{32'h03F00013, IMM_SHAMT, 64'h0000_001F, 1'b0};
      v32[10] = '{32'h00500013, IMM_SHAMT, 64'h0000_0005, 1'b0};
      v32[11] = '{32'h800F8073, IMM_ZIMM,  zexp,          zill};
      v32[12] = '{32'hFFFFFFFF, IMM_ILL,   64'h0,         1'b1};
      v32[13] = '{32'h00000000, IMM_I,     64'h0,         1'b0};

      v64[0] = '{32'hFFF00093, IMM_I,     64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      v64[1] = '{32'hFE000EE3, IMM_B,     64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
      v64[2] = '{32'h80000037, IMM_U,     64'hFFFF_FFFF_8000_0000, 1'b0};
      v64[3] = '{32'h12345037, IMM_U,     64'h0000_0000_1234_5000, 1'b0};
      v64[4] = '{32'h03F00013, IMM_SHAMT, 64'h0000_0000_0000_003F, 1'b0};
      v64[5] = '{32'hFFFFFFFF, IMM_ILL,   64'h0,                   1'b1};

      drive32(1'b0, 32'h0, IMM_I, 5'd0);
      b32.out_ready  = 1'b1;
      b64.in_valid   = 1'b0;
      b64.in_instr   = '0;
      b64.in_imm_src = IMM_I;
      b64.in_tag     = '0;
      b64.out_ready  = 1'b1;

      // Reset state while rst_n is held low
      #2;
      chk("rst_out_valid", 64'(b32.out_valid), 64'h0);
      chk("rst_in_ready",  64'(b32.in_ready),  64'h1);
      chk("rst_out_imm",   64'(b32.out_imm),   64'h0);
      chk("rst_out_tag",   64'(b32.out_tag),   64'h0);
      chk("rst_out_ill",   64'(b32.out_illegal), 64'h0);
      #10 rst_n = 1'b1;
      cyc();

      // XLEN=32 table, back-to-back with out_ready=1 (accept and consume together)
      for (int i = 0; i < 14; i++) begin
         drive32(1'b1, v32[i].instr, v32[i].src, 5'(i));
         cyc();
         chk($sformatf("v32[%0d]_valid", i), 64'(b32.out_valid),   64'h1);
         chk($sformatf("v32[%0d]_imm", i),   64'(b32.out_imm),     v32[i].exp);
         chk($sformatf("v32[%0d]_ill", i),   64'(b32.out_illegal), 64'(v32[i].ill));
         chk($sformatf("v32[%0d]_tag", i),   64'(b32.out_tag),     64'(i));
      end
      b32.in_valid = 1'b0;
      cyc();
      chk("v32_drain_valid", 64'(b32.out_valid), 64'h0);

      // XLEN=64 table
      for (int i = 0; i < 6; i++) begin
         b64.in_valid   = 1'b1;
         b64.in_instr   = v64[i].instr[31:7];
         b64.in_imm_src = v64[i].src;
         b64.in_tag     = 5'(i + 16);
         cyc();
         chk($sformatf("v64[%0d]_valid", i), 64'(b64.out_valid),   64'h1);
         chk($sformatf("v64[%0d]_imm", i),   b64.out_imm,          v64[i].exp);
         chk($sformatf("v64[%0d]_ill", i),   64'(b64.out_illegal), 64'(v64[i].ill));
         chk($sformatf("v64[%0d]_tag", i),   64'(b64.out_tag),     64'(i + 16));
      end
      b64.in_valid = 1'b0;
      cyc();

      // Backpressure: two beats fill output and skid
      b32.out_ready = 1'b0;
      drive32(1'b1, 32'hFFF00093, IMM_I, 5'd1);
      cyc();
      chk("bp_in_ready_1", 64'(b32.in_ready), 64'h1);
      chk("bp_tag_1",      64'(b32.out_tag),  64'h1);
      drive32(1'b1, 32'h7FF00013, IMM_I, 5'd2);
      cyc();
      b32.in_valid = 1'b0;
      chk("bp_in_ready_2", 64'(b32.in_ready), 64'h0);
      chk("bp_tag_hold",   64'(b32.out_tag),  64'h1);
      cyc();
      chk("bp_tag_stable", 64'(b32.out_tag),  64'h1);
      chk("bp_imm_stable", 64'(b32.out_imm),  64'hFFFF_FFFF);
      chk("bp_valid_hold", 64'(b32.out_valid), 64'h1);
      b32.out_ready = 1'b1;
      cyc();
      chk("bp_tag_2",      64'(b32.out_tag),  64'h2);
      chk("bp_imm_2",      64'(b32.out_imm),  64'h7FF);
      chk("bp_in_ready_3", 64'(b32.in_ready), 64'h1);
      cyc();
      chk("bp_drained",    64'(b32.out_valid), 64'h0);

      // Flush with both registers full plus a beat offered in the flush cycle
      b32.out_ready = 1'b0;
      drive32(1'b1, 32'h00500013, IMM_SHAMT, 5'd3);
      cyc();
      drive32(1'b1, 32'h00500013, IMM_SHAMT, 5'd4);
      cyc();
      chk("fl_full", 64'(b32.in_ready), 64'h0);
      drive32(1'b1, 32'h00500013, IMM_SHAMT, 5'd5);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      b32.in_valid = 1'b0;
      chk("fl_out_valid", 64'(b32.out_valid), 64'h0);
      chk("fl_in_ready",  64'(b32.in_ready),  64'h1);
      b32.out_ready = 1'b1;
      cyc();
      chk("fl_no_ghost",  64'(b32.out_valid), 64'h0);
      // Flush overrides a simultaneous accept and consume
      drive32(1'b1, 32'h7FF00013, IMM_I, 5'd6);
      cyc();
      chk("fl2_tag6",     64'(b32.out_tag),   64'h6);
      drive32(1'b1, 32'h7FF00013, IMM_I, 5'd7);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      b32.in_valid = 1'b0;
      chk("fl2_out_valid", 64'(b32.out_valid), 64'h0);
      cyc();
      chk("fl2_no_ghost",  64'(b32.out_valid), 64'h0);

      // Asynchronous reset while the skid is full
      b32.out_ready = 1'b0;
      drive32(1'b1, 32'hFFF00093, IMM_I, 5'd8);
      cyc();
      drive32(1'b1, 32'hFFF00093, IMM_I, 5'd9);
      cyc();
      b32.in_valid = 1'b0;
      chk("ar_full",      64'(b32.in_ready),  64'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 64'(b32.out_valid), 64'h0);
      chk("ar_in_ready",  64'(b32.in_ready),  64'h1);
      chk("ar_out_imm",   64'(b32.out_imm),   64'h0);
      chk("ar_out_tag",   64'(b32.out_tag),   64'h0);
      #2 rst_n = 1'b1;
      b32.out_ready = 1'b1;
      cyc();
      chk("ar_lost",      64'(b32.out_valid), 64'h0);
      drive32(1'b1, 32'h03F00013, IMM_SHAMT, 5'd10);
      cyc();
      b32.in_valid = 1'b0;
      chk("ar_after_imm", 64'(b32.out_imm),   64'h1F);
      chk("ar_after_tag", 64'(b32.out_tag),   64'hA);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
